// File: rtl/interconnect_router.sv
// interconnect_router: routes SPI-minion messages between the SPI adapter
// and NUM_BLOCKS internal blocks.
//   Request path : decodes {addr, data}, forwards data to block 'addr' through a
//                  one-entry register; out-of-range addresses are accepted and dropped.
//   Response path: round-robin arbiter over block responses into a one-entry
//                  output register, tagged with the source block index.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   req_msg/req_val/req_rdy         {addr, data} stream from the SPI adapter
//   blk_req_data/val/rdy            shared payload, one-hot valid, per-block ready
//   blk_resp_data/val/rdy           packed per-block responses, valid, one-hot ready
//   resp_msg/resp_val/resp_rdy      {source addr, data} stream to the SPI adapter
//   err_count                       saturating count of dropped requests
// Configuration macro: ROUTER_ERR_COUNT_EN enables the dropped-request counter;
// when undefined err_count is tied to zero.
module interconnect_router #(
    parameter int unsigned NUM_BLOCKS = 4,
    parameter int unsigned ADDR_BITS  = 4,
    parameter int unsigned DATA_BITS  = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [ADDR_BITS+DATA_BITS-1:0]  req_msg,
    input  logic                            req_val,
    output logic                            req_rdy,
    output logic [DATA_BITS-1:0]            blk_req_data,
    output logic [NUM_BLOCKS-1:0]           blk_req_val,
    input  logic [NUM_BLOCKS-1:0]           blk_req_rdy,
    input  logic [NUM_BLOCKS*DATA_BITS-1:0] blk_resp_data,
    input  logic [NUM_BLOCKS-1:0]           blk_resp_val,
    output logic [NUM_BLOCKS-1:0]           blk_resp_rdy,
    output logic [ADDR_BITS+DATA_BITS-1:0]  resp_msg,
    output logic                            resp_val,
    input  logic                            resp_rdy,
    output logic [7:0]                      err_count
);

    localparam int unsigned MSG_BITS = ADDR_BITS + DATA_BITS;
    localparam int unsigned PTR_BITS = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
    // One extra bit so NUM_BLOCKS == 2^ADDR_BITS still compares correctly.
    localparam int unsigned CMP_BITS = ADDR_BITS + 1;

    // ------------------------------------------------------------------
    // Request path
    // ------------------------------------------------------------------
    logic [ADDR_BITS-1:0] req_addr;
    logic [DATA_BITS-1:0] req_data;
    logic                 req_in_range;

    assign req_addr     = req_msg[MSG_BITS-1 -: ADDR_BITS];
    assign req_data     = req_msg[DATA_BITS-1:0];
    assign req_in_range = CMP_BITS'(req_addr) < CMP_BITS'(NUM_BLOCKS);

    // The register stores its destination one-hot, so its occupancy is |blk_req_val
    // and the drain condition needs no decode of a binary index.
    assign req_rdy = ~(|blk_req_val) | (|(blk_req_val & blk_req_rdy));

    // One-entry request register; refills in the same cycle it drains.
    always_ff @(posedge clk) begin
        if (reset) begin
            blk_req_val  <= '0;
            blk_req_data <= '0;
        end else if (req_rdy) begin
            if (req_val && req_in_range) begin
                blk_req_val  <= NUM_BLOCKS'(1) << req_addr;
                blk_req_data <= req_data;
            end else begin
                blk_req_val  <= '0;
            end
        end
    end

`ifdef ROUTER_ERR_COUNT_EN
    logic [7:0] err_q;

    // Saturating count of accepted-and-dropped out-of-range requests.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= '0;
        end else if (req_val && req_rdy && !req_in_range && err_q != 8'hFF) begin
            err_q <= err_q + 8'd1;
        end
    end

    assign err_count = err_q;
`else
    assign err_count = 8'd0;
`endif

    // ------------------------------------------------------------------
    // Response path
    // ------------------------------------------------------------------
    logic [PTR_BITS-1:0]  ptr;
    logic [PTR_BITS-1:0]  grant_idx;
    logic [PTR_BITS-1:0]  ptr_next;
    logic                 grant_any;
    logic                 resp_take;
    logic [DATA_BITS-1:0] grant_data;

    // Round-robin pick: lowest valid index >= ptr, else lowest valid index overall.
    always_comb begin : arb
        logic                hi_found;
        logic [PTR_BITS-1:0] hi_idx;
        logic [PTR_BITS-1:0] lo_idx;
        hi_found  = 1'b0;
        hi_idx    = '0;
        lo_idx    = '0;
        grant_any = 1'b0;
        for (int i = int'(NUM_BLOCKS) - 1; i >= 0; i--) begin
            if (blk_resp_val[i]) begin
                grant_any = 1'b1;
                lo_idx    = PTR_BITS'(i);
                if (PTR_BITS'(i) >= ptr) begin
                    hi_found = 1'b1;
                    hi_idx   = PTR_BITS'(i);
                end
            end
        end
        grant_idx = hi_found ? hi_idx : lo_idx;
    end

    // Payload mux for the granted block.
    always_comb begin
        grant_data = '0;
        for (int i = 0; i < int'(NUM_BLOCKS); i++) begin
            if (PTR_BITS'(i) == grant_idx) begin
                grant_data = blk_resp_data[i*DATA_BITS +: DATA_BITS];
            end
        end
    end

    assign ptr_next     = (32'(grant_idx) == NUM_BLOCKS - 1) ? '0 : grant_idx + PTR_BITS'(1);
    assign resp_take    = grant_any && (!resp_val || resp_rdy);
    assign blk_resp_rdy = resp_take ? (NUM_BLOCKS'(1) << grant_idx) : '0;

    // One-entry response register and round-robin pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            resp_val <= 1'b0;
            resp_msg <= '0;
            ptr      <= '0;
        end else if (resp_take) begin
            resp_val <= 1'b1;
            resp_msg <= {ADDR_BITS'(grant_idx), grant_data};
            ptr      <= ptr_next;
        end else if (resp_rdy) begin
            resp_val <= 1'b0;
        end
    end

endmodule

// File: tb/tb_interconnect_router.sv
// Scoreboard bench for interconnect_router (NUM_BLOCKS=4, ADDR_BITS=4, DATA_BITS=16).
// Drivers feed request/block-response queues; monitors pop expected messages
// whenever the DUT completes a transfer.
module tb_interconnect_router;

    localparam int unsigned NB = 4;
    localparam int unsigned AB = 4;
    localparam int unsigned DB = 16;
`ifdef ROUTER_ERR_COUNT_EN
    localparam int unsigned ERR_AFTER_3   = 3;
    localparam int unsigned ERR_AFTER_300 = 255;
`else
    localparam int unsigned ERR_AFTER_3   = 0;
    localparam int unsigned ERR_AFTER_300 = 0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic [AB+DB-1:0]  req_msg;
    logic              req_val;
    logic              req_rdy;
    logic [DB-1:0]     blk_req_data;
    logic [NB-1:0]     blk_req_val;
    logic [NB-1:0]     blk_req_rdy;
    logic [NB*DB-1:0]  blk_resp_data;
    logic [NB-1:0]     blk_resp_val;
    logic [NB-1:0]     blk_resp_rdy;
    logic [AB+DB-1:0]  resp_msg;
    logic              resp_val;
    logic              resp_rdy;
    logic [7:0]        err_count;

    interconnect_router #(.NUM_BLOCKS(NB), .ADDR_BITS(AB), .DATA_BITS(DB)) dut (
        .clk(clk), .reset(reset),
        .req_msg(req_msg), .req_val(req_val), .req_rdy(req_rdy),
        .blk_req_data(blk_req_data), .blk_req_val(blk_req_val), .blk_req_rdy(blk_req_rdy),
        .blk_resp_data(blk_resp_data), .blk_resp_val(blk_resp_val), .blk_resp_rdy(blk_resp_rdy),
        .resp_msg(resp_msg), .resp_val(resp_val), .resp_rdy(resp_rdy),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    logic [AB+DB-1:0] req_q[$];
    logic [AB+DB-1:0] exp_req[$];
    logic [AB+DB-1:0] exp_resp[$];
    logic [DB-1:0]    blk_q[NB][$];
    int               resp_cycles[$];

    logic             req_fire;
    logic [NB-1:0]    blk_fire;
    bit               phase_drop = 1'b0;
    bit               drop_seen  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_req(input logic [AB-1:0] a, input logic [DB-1:0] d, input bit expect_out);
        req_q.push_back({a, d});
        if (expect_out) exp_req.push_back({a, d});
    endtask

    task automatic push_blk(input int b, input logic [DB-1:0] d);
        blk_q[b].push_back(d);
    endtask

    function automatic bit drivers_idle();
        bit idle = (req_q.size() == 0);
        for (int i = 0; i < int'(NB); i++) if (blk_q[i].size() != 0) idle = 1'b0;
        return idle;
    endfunction

    task automatic wait_drv(input int max_cyc, input string name);
        bit ok = 1'b0;
        for (int n = 0; n < max_cyc && !ok; n++) begin
            @(posedge clk); #3;
            ok = drivers_idle();
        end
        check(name, 32'(ok), 32'd1);
    endtask

    task automatic wait_all(input int max_cyc, input string name);
        bit ok = 1'b0;
        for (int n = 0; n < max_cyc && !ok; n++) begin
            @(posedge clk); #3;
            ok = drivers_idle() && exp_req.size() == 0 && exp_resp.size() == 0;
        end
        check(name, 32'(ok), 32'd1);
    endtask

    task automatic wait_req_fire(input string name);
        bit ok = 1'b0;
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge clk);
            ok = req_val && req_rdy;
        end
        check(name, 32'(ok), 32'd1);
    endtask

    always @(posedge clk) cyc++;

    // Transfers are sampled mid-cycle, queues advance just after the edge.
    always @(negedge clk) begin
        req_fire = req_val && req_rdy;
        blk_fire = blk_resp_val & blk_resp_rdy;
    end

    always @(posedge clk) begin
        #2;
        if (req_fire && req_q.size() > 0) void'(req_q.pop_front());
        for (int i = 0; i < int'(NB); i++)
            if (blk_fire[i] && blk_q[i].size() > 0) void'(blk_q[i].pop_front());
        req_val = (req_q.size() > 0);
        req_msg = req_val ? req_q[0] : '0;
        for (int i = 0; i < int'(NB); i++) begin
            blk_resp_val[i]           = (blk_q[i].size() > 0);
            blk_resp_data[i*DB +: DB] = blk_resp_val[i] ? blk_q[i][0] : '0;
        end
    end

    // Request-side monitor.
    always @(negedge clk) begin
        logic [AB+DB-1:0] e;
        logic [AB-1:0]    dest;
        if (!reset) begin
            if (phase_drop && |blk_req_val) drop_seen = 1'b1;
            if (|blk_req_val) begin
                check("blk_req_val_onehot", 32'($onehot(blk_req_val)), 32'd1);
                check("req_rdy_passthru", 32'(req_rdy), 32'(|(blk_req_val & blk_req_rdy)));
                if (|(blk_req_val & blk_req_rdy)) begin
                    if (exp_req.size() == 0) begin
                        tests_run++;
                        tests_failed++;
                        $display("FAIL req_unexpected: got val=0x%0h data=0x%0h, expected no delivery",
                                 blk_req_val, blk_req_data);
                    end else begin
                        e    = exp_req.pop_front();
                        dest = '0;
                        for (int i = 0; i < int'(NB); i++) if (blk_req_val[i]) dest = AB'(i);
                        check("req_dest", 32'(dest), 32'(e[AB+DB-1:DB]));
                        check("req_data", 32'(blk_req_data), 32'(e[DB-1:0]));
                    end
                end
            end else begin
                check("req_rdy_idle", 32'(req_rdy), 32'd1);
            end
        end
    end

    // Response-side monitor.
    always @(negedge clk) begin
        logic [AB+DB-1:0] e;
        if (!reset) begin
            if ((blk_resp_rdy & ~blk_resp_val) != '0 || !$onehot0(blk_resp_rdy))
                check("blk_resp_rdy_legal", 32'(blk_resp_rdy), 32'(blk_resp_rdy & blk_resp_val));
            if (resp_val && !resp_rdy)
                check("blk_resp_rdy_stall", 32'(blk_resp_rdy), 32'd0);
            if (resp_val && resp_rdy) begin
                resp_cycles.push_back(cyc);
                if (exp_resp.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("FAIL resp_unexpected: got 0x%0h, expected no response", resp_msg);
                end else begin
                    e = exp_resp.pop_front();
                    check("resp_msg", 32'(resp_msg), 32'(e));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b1;
        req_val       = 1'b0;
        req_msg       = '0;
        blk_req_rdy   = '1;
        blk_resp_val  = '0;
        blk_resp_data = '0;
        resp_rdy      = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state.
        @(negedge clk);
        check("rst_blk_req_val", 32'(blk_req_val), 32'd0);
        check("rst_blk_req_data", 32'(blk_req_data), 32'd0);
        check("rst_resp_val", 32'(resp_val), 32'd0);
        check("rst_resp_msg", 32'(resp_msg), 32'd0);
        check("rst_blk_resp_rdy", 32'(blk_resp_rdy), 32'd0);
        check("rst_err_count", 32'(err_count), 32'd0);
        check("rst_req_rdy", 32'(req_rdy), 32'd1);

        // Single request, one-cycle latency.
        @(posedge clk); #1;
        push_req(4'd2, 16'hBEEF, 1'b1);
        wait_req_fire("t1_fire");
        @(negedge clk);
        check("t1_blk_req_val", 32'(blk_req_val), 32'h4);
        check("t1_blk_req_data", 32'(blk_req_data), 32'hBEEF);
        wait_all(50, "t1_drain");

        // Back-to-back with block 1 stalled: order 1, 1, 3.
        @(posedge clk); #1;
        blk_req_rdy = 4'b1101;
        push_req(4'd1, 16'hA001, 1'b1);
        push_req(4'd1, 16'hA002, 1'b1);
        push_req(4'd3, 16'hA003, 1'b1);
        wait_req_fire("t2_fire");
        @(negedge clk);
        check("t2_req_rdy_low", 32'(req_rdy), 32'd0);
        check("t2_held_val", 32'(blk_req_val), 32'h2);
        repeat (2) @(posedge clk);
        #1 blk_req_rdy = '1;
        wait_all(50, "t2_drain");

        // All blocks valid: round-robin 0, 1, 2, 3, 0 one per cycle.
        @(posedge clk); #1;
        resp_cycles.delete();
        push_blk(0, 16'h1000); push_blk(0, 16'h1000);
        push_blk(1, 16'h1001); push_blk(2, 16'h1002); push_blk(3, 16'h1003);
        exp_resp.push_back({4'd0, 16'h1000});
        exp_resp.push_back({4'd1, 16'h1001});
        exp_resp.push_back({4'd2, 16'h1002});
        exp_resp.push_back({4'd3, 16'h1003});
        exp_resp.push_back({4'd0, 16'h1000});
        wait_all(50, "t3_drain");
        check("t3_resp_count", 32'(resp_cycles.size()), 32'd5);
        if (resp_cycles.size() == 5)
            check("t3_back_to_back", 32'(resp_cycles[4] - resp_cycles[0]), 32'd4);

        // Blocks 1 and 3 with toggling resp_rdy: grants 1, 3, 1.
        @(posedge clk); #1;
        push_blk(1, 16'h2101); push_blk(1, 16'h2102); push_blk(3, 16'h2301);
        exp_resp.push_back({4'd1, 16'h2101});
        exp_resp.push_back({4'd3, 16'h2301});
        exp_resp.push_back({4'd1, 16'h2102});
        begin
            bit done = 1'b0;
            for (int n = 0; n < 40 && !done; n++) begin
                @(posedge clk); #1;
                resp_rdy = ~resp_rdy;
                done = drivers_idle() && exp_resp.size() == 0;
            end
            check("t4_drain", 32'(done), 32'd1);
        end
        resp_rdy = 1'b1;
        repeat (3) @(posedge clk);

        // Out-of-range requests are dropped and counted.
        #1;
        phase_drop = 1'b1;
        drop_seen  = 1'b0;
        for (int i = 0; i < 3; i++) push_req(4'd7, 16'(16'hE000 + i), 1'b0);
        wait_drv(20, "t5_drain3");
        @(negedge clk);
        check("t5_err_after_3", 32'(err_count), ERR_AFTER_3);
        @(posedge clk); #1;
        for (int i = 3; i < 300; i++) push_req(4'd7, 16'(16'hE000 + i), 1'b0);
        wait_drv(400, "t5_drain300");
        @(negedge clk);
        check("t5_err_after_300", 32'(err_count), ERR_AFTER_300);
        check("t5_no_blk_req_val", 32'(drop_seen), 32'd0);
        phase_drop = 1'b0;

        // Reset with both registers occupied discards the held messages.
        @(posedge clk); #1;
        blk_req_rdy = 4'b1110;
        resp_rdy    = 1'b0;
        push_req(4'd0, 16'hDEAD, 1'b0);
        push_blk(2, 16'h2222);
        wait_drv(20, "t6_load");
        @(negedge clk);
        check("t6_req_held", 32'(blk_req_val), 32'h1);
        check("t6_resp_held", 32'(resp_val), 32'd1);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("t6_blk_req_val", 32'(blk_req_val), 32'd0);
        check("t6_resp_val", 32'(resp_val), 32'd0);
        check("t6_resp_msg", 32'(resp_msg), 32'd0);
        check("t6_err_count", 32'(err_count), 32'd0);
        @(posedge clk); #1;
        blk_req_rdy = '1;
        resp_rdy    = 1'b1;
        repeat (5) @(posedge clk);

        // Pointer restarts at 0: block 1 wins over block 3.
        #1;
        push_blk(1, 16'h3101);
        push_blk(3, 16'h3301);
        exp_resp.push_back({4'd1, 16'h3101});
        exp_resp.push_back({4'd3, 16'h3301});
        wait_all(50, "t7_drain");

        repeat (3) @(posedge clk);
        check("final_exp_req_empty", 32'(exp_req.size()), 32'd0);
        check("final_exp_resp_empty", 32'(exp_resp.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/interconnect_router.md
# interconnect_router

Routes SPI-minion messages between the tape-in SPI adapter and up to NUM_BLOCKS internal blocks. It sits inside the top-level interconnect, between the SPI adapter's val/rdy streams and the per-block streams. The request path decodes an address field and forwards the payload to one block through a one-entry pipeline register. The response path round-robin arbitrates block responses back to the adapter, tagged with the source address.

## Interface
- NUM_BLOCKS, 4: number of attached blocks (2..16)
- ADDR_BITS, 4: address field width; must satisfy 2^ADDR_BITS >= NUM_BLOCKS
- DATA_BITS, 16: payload width
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_msg  in  ADDR_BITS+DATA_BITS  {addr, data} from the SPI adapter
- req_val  in  1  request valid
- req_rdy  out  1  request ready
- blk_req_data  out  DATA_BITS  payload shared by all blocks
- blk_req_val  out  NUM_BLOCKS  one-hot valid per block
- blk_req_rdy  in  NUM_BLOCKS  per-block ready
- blk_resp_data  in  NUM_BLOCKS*DATA_BITS  block i occupies bits [i*DATA_BITS +: DATA_BITS]
- blk_resp_val  in  NUM_BLOCKS  per-block response valid
- blk_resp_rdy  out  NUM_BLOCKS  per-block response ready (at most one bit high)
- resp_msg  out  ADDR_BITS+DATA_BITS  {source addr, data} to the SPI adapter
- resp_val  out  1  response valid
- resp_rdy  in  1  adapter ready
- err_count  out  8  count of dropped out-of-range requests

## Operation
- A transfer occurs on any stream when val && rdy are both high at a clk edge.
- **Request path:** one-entry register holding {valid, dest, data}.
  - req_rdy = !q_valid || blk_req_rdy[q_dest] (pass-through ready; the register refills in the cycle it drains).
  - On a request transfer with addr < NUM_BLOCKS: load the register with dest = addr.
  - On a request transfer with addr >= NUM_BLOCKS: accept and drop the message; the register is not loaded; err_count action depends on configuration.
  - blk_req_val = q_valid ? (1 << q_dest) : 0. blk_req_data = q_data.
- **Response path:** one-entry output register plus a round-robin pointer ptr, reset value 0.
  - Grant goes to the first i with blk_resp_val[i] set, scanning ptr, ptr+1, … mod NUM_BLOCKS.
  - blk_resp_rdy[i] = grant[i] && (!resp_val || resp_rdy).
  - On a block transfer: register {i[ADDR_BITS-1:0], data_i}, then ptr <= (i+1) mod NUM_BLOCKS.
  - ptr does not move on cycles with no transfer.
- The request and response paths are fully independent; simultaneous activity on both never stalls either.
- **Reset values:** req register empty; blk_req_val = 0; resp_val = 0; resp_msg = 0; blk_resp_rdy = 0; ptr = 0; err_count = 0. blk_req_data = 0.
- **Reset mid-operation:** buffered messages are discarded, not delivered.

## Timing
- Request latency: transfer at edge N makes blk_req_val[dest] high after edge N, visible in cycle N+1.
- Request throughput: 1 message per cycle while the destination block stays ready.
- Response latency: block transfer at edge N makes resp_val high in cycle N+1.
- Response throughput: 1 message per cycle while resp_rdy stays high.
- Combinational paths: req_rdy depends on blk_req_rdy; blk_resp_rdy depends on resp_rdy and blk_resp_val. No other combinational paths from input to output.
- Backpressure: a stalled destination holds q_valid and drops req_rdy. Requests for other blocks also stall; there is no reordering.

## Configuration
- ROUTER_ERR_COUNT_EN defined:
  - err_count increments by 1 on each dropped out-of-range request.
  - It saturates at 255 and clears only on reset.
- ROUTER_ERR_COUNT_EN undefined:
  - err_count is tied to 0 and the counter logic is absent.
  - Out-of-range requests are still accepted and dropped.

## Test plan
- Reset, then idle: all valids 0, err_count 0, ptr 0. Request {addr=2, data=0xBEEF} with blk_req_rdy=all ones -> blk_req_val=4'b0100 and blk_req_data=0xBEEF one cycle later.
- Back-to-back requests to addr 1, then 1, then 3 with blk_req_rdy[1] low for 3 cycles:
  - req_rdy goes low while the first message is held.
  - Delivery order is 1, 1, 3 with no loss.
- All four blk_resp_val high continuously with data 0x1000+i, resp_rdy=1 -> resp_msg sources in order 0, 1, 2, 3, 0, one per cycle.
- Only blocks 1 and 3 valid with resp_rdy toggling 1/0:
  - Grants alternate 1, 3, 1.
  - No block response is lost or duplicated.
  - blk_resp_rdy is all zero while resp_val && !resp_rdy.
- 300 requests with addr=7 (NUM_BLOCKS=4):
  - With ROUTER_ERR_COUNT_EN: err_count = 255 and blk_req_val never asserted.
  - Without the macro: err_count = 0 and blk_req_val never asserted.
- Assert reset while both registers hold messages -> next cycle blk_req_val=0, resp_val=0, and the held messages never appear.
